cpu_boot_ctrl: RTL and testbench
================================

CPU_BOOT_CTRL -- requirements
Module: cpu_boot_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: number of cycles the core is held in reset after reset_n deasserts; legal range 1..255.
REQ-002 Parameter NUM_REGS, default 32: number of register-file entries cleared at boot.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 Port clk, input, 1 bit: single clock; every state element updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset that is synchronous and active-low.
REQ-006 Port halt_req, input, 1 bit: single-cycle pulse from the debug/testbench side requesting a halt.
REQ-007 Port resume_req, input, 1 bit: single-cycle pulse requesting a resume.
REQ-008 Port pipe_empty, input, 1 bit: high when no valid instruction is present in ID, EX, MEM or WB.
REQ-009 Port core_rst_n, output, 1 bit: active-low reset to the pipeline registers and PC.
REQ-010 Port rf_clr_we, output, 1 bit: register-file clear write enable; the write data is zero.
REQ-011 Port rf_clr_addr, output, 5 bits: register-file clear address.
REQ-012 Port pc_load, output, 1 bit: loads pc_init into the PC.
REQ-013 Port pc_init, output, 32 bits: constant equal to RESET_PC.
REQ-014 Port fetch_stall, output, 1 bit: freezes the PC and the IF/ID register while downstream stages continue draining.
REQ-015 Port halted, output, 1 bit: high while the core is halted.
REQ-016 Port state_o, output, 3 bits: encoding of the current state, for debug.

Function
REQ-017 The FSM shall have the states RESET_HOLD, RF_CLEAR, BOOT, RUN, DRAIN and HALTED; all outputs are Moore decodes of the registered state, the counter and the pending flag.
REQ-018 In RESET_HOLD, core_rst_n=0 and fetch_stall=1, and the cycle counter increments each cycle; at the edge where the counter equals HOLD_CYCLES-1, the FSM moves to RF_CLEAR and the counter resets to 0.
REQ-019 In RF_CLEAR, core_rst_n=0, fetch_stall=1, rf_clr_we=1 and rf_clr_addr equals the counter, covering 0..NUM_REGS-1 with one address per cycle; after address NUM_REGS-1, the FSM moves to BOOT.
REQ-020 BOOT shall last exactly one cycle, with core_rst_n=1, pc_load=1 and fetch_stall=1; the next state is RUN, or DRAIN if halt_pend=1.
REQ-021 In RUN, fetch_stall=0; halt_req=1 moves the FSM to DRAIN.
REQ-022 In DRAIN, fetch_stall=1; pipe_empty=1 moves the FSM to HALTED, and resume_req=1 returns it to RUN.
REQ-023 In HALTED, fetch_stall=1 and halted=1; resume_req=1 moves the FSM to RUN, and halt_req is ignored.
REQ-024 halt_req asserted in RESET_HOLD, RF_CLEAR or BOOT shall set the flag halt_pend; halt_pend clears on entry to DRAIN.
REQ-025 resume_req in RESET_HOLD, RF_CLEAR or BOOT shall be ignored, and it does not clear halt_pend.
REQ-026 Simultaneous events shall resolve as follows: halt_req and resume_req together in RUN give halt; in DRAIN, resume_req together with pipe_empty gives RUN; in HALTED, halt_req together with resume_req gives RUN.
REQ-027 With default parameters, core_rst_n shall rise after exactly HOLD_CYCLES+NUM_REGS=48 rising edges following the first edge that samples reset_n=1, and RUN shall be entered one edge later.
REQ-028 rf_clr_we, pc_load and halted shall be 0 in every state not listed for them above; core_rst_n shall be 1 in BOOT, RUN, DRAIN and HALTED.

Reset
REQ-029 reset_n=0 at a rising edge, in any state, shall force state=RESET_HOLD, counter=0 and halt_pend=0.
REQ-030 During reset, the outputs shall be: core_rst_n=0, rf_clr_we=0, rf_clr_addr=0, pc_load=0, fetch_stall=1, halted=0, state_o=RESET_HOLD encoding, pc_init=RESET_PC.
REQ-031 A reset asserted mid-clear or mid-drain shall abandon the operation without any further rf_clr_we or pc_load pulse, and the full boot sequence restarts on release.

Structure
REQ-032 A shared package cpu_ctrl_pkg shall hold the boot_state_t enum (RESET_HOLD=0, RF_CLEAR=1, BOOT=2, RUN=3, DRAIN=4, HALTED=5), the register-address width (5) and the XLEN constant (32).
REQ-033 A single sub-module seq_counter shall provide the counter: 8 bits wide, with synchronous clear, enable and terminal-count compare, and it is shared by RESET_HOLD and RF_CLEAR.

Verification
REQ-034 Release reset_n at edge E0 with default parameters, then expect: rf_clr_we high for 32 cycles with addresses 0..31 in order; pc_load=1 for one cycle with pc_init=0; core_rst_n=1 from edge E48; fetch_stall=0 from edge E49.
REQ-035 In RUN, pulse halt_req while holding pipe_empty=0 for 5 cycles then 1, and expect: DRAIN with fetch_stall=1; halted=1 on the edge after pipe_empty rises; resume_req then gives RUN with fetch_stall=0 one edge later.
REQ-036 Pulse halt_req during RF_CLEAR (address 10), and expect: BOOT then DRAIN with no RUN cycle; with pipe_empty=1, HALTED.
REQ-037 Assert halt_req and resume_req in the same cycle in RUN, and expect DRAIN; assert both in HALTED, and expect RUN; assert resume_req together with pipe_empty in DRAIN, and expect RUN.
REQ-038 Assert reset_n=0 for one cycle at rf_clr_addr=20, and expect: rf_clr_we=0 and state_o=RESET_HOLD on the next edge; the full 48-edge sequence repeats from address 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU boot/halt controller.
// Also provides a small helper that identifies the boot-time states.
package cpu_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RF_CLEAR   = 3'd1,
    BOOT       = 3'd2,
    RUN        = 3'd3,
    DRAIN      = 3'd4,
    HALTED     = 3'd5
  } boot_state_t;

  // True while the core is still being brought out of reset.
  function automatic logic is_boot_phase(input boot_state_t s);
    return (s == RESET_HOLD) || (s == RF_CLEAR) || (s == BOOT);
  endfunction

endpackage

// File: rtl/cpu_boot_ctrl_seq_counter.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
// The next count is exported so the owner can register decodes of it.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] count_d_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next-count selection: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_d_o = count_d;
  assign tc_o      = (count_q == tc_val_i);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer for the pipeline: reset hold, register-file clear, PC load,
// then run with a debug halt/drain/resume path. All outputs are registered.
module cpu_boot_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     HOLD_CYCLES = 16,
  parameter int unsigned     NUM_REGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              pipe_empty,
  output logic              core_rst_n,
  output logic              rf_clr_we,
  output logic [REG_AW-1:0] rf_clr_addr,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_init,
  output logic              fetch_stall,
  output logic              halted,
  output logic [2:0]        state_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(NUM_REGS - 1);

  boot_state_t       state_q;
  boot_state_t       state_d;
  logic              halt_pend_q;
  logic              halt_pend_d;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              cnt_tc_s;
  logic [CNT_W-1:0]  cnt_tc_val_s;
  logic [CNT_W-1:0]  cnt_d_s;

  logic              core_rst_n_q;
  logic              rf_clr_we_q;
  logic [REG_AW-1:0] rf_clr_addr_q;
  logic              pc_load_q;
  logic              fetch_stall_q;
  logic              halted_q;

  seq_counter #(
    .W (CNT_W)
  ) u_seq_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (cnt_clr_s),
    .en_i      (cnt_en_s),
    .tc_val_i  (cnt_tc_val_s),
    .count_d_o (cnt_d_s),
    .tc_o      (cnt_tc_s)
  );

  // Next-state, pending-halt and counter-control decode.
  always_comb begin
    state_d      = state_q;
    halt_pend_d  = halt_pend_q;
    cnt_clr_s    = 1'b1;
    cnt_en_s     = 1'b0;
    cnt_tc_val_s = HOLD_LAST;

    if (is_boot_phase(state_q) && halt_req) begin
      halt_pend_d = 1'b1;
    end else begin
      halt_pend_d = halt_pend_q;
    end

    case (state_q)
      RESET_HOLD: begin
        cnt_tc_val_s = HOLD_LAST;
        if (cnt_tc_s) begin
          state_d = RF_CLEAR;
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end
      end
      RF_CLEAR: begin
        cnt_tc_val_s = CLR_LAST;
        if (cnt_tc_s) begin
          state_d = BOOT;
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end
      end
      BOOT: begin
        // A halt requested in this very cycle is honoured too.
        if (halt_pend_q || halt_req) begin
          state_d     = DRAIN;
          halt_pend_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d     = DRAIN;
          halt_pend_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (resume_req) begin
          state_d = RUN;
        end else if (pipe_empty) begin
          state_d = HALTED;
        end else begin
          state_d = DRAIN;
        end
      end
      HALTED: begin
        if (resume_req) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d     = RESET_HOLD;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  // State, pending flag and outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RESET_HOLD;
      halt_pend_q   <= 1'b0;
      core_rst_n_q  <= 1'b0;
      rf_clr_we_q   <= 1'b0;
      rf_clr_addr_q <= {REG_AW{1'b0}};
      pc_load_q     <= 1'b0;
      fetch_stall_q <= 1'b1;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_pend_q   <= halt_pend_d;
      core_rst_n_q  <= ((state_d == RESET_HOLD) || (state_d == RF_CLEAR)) ? 1'b0 : 1'b1;
      rf_clr_we_q   <= (state_d == RF_CLEAR);
      rf_clr_addr_q <= (state_d == RF_CLEAR) ? REG_AW'(cnt_d_s) : {REG_AW{1'b0}};
      pc_load_q     <= (state_d == BOOT);
      fetch_stall_q <= (state_d != RUN);
      halted_q      <= (state_d == HALTED);
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign rf_clr_we   = rf_clr_we_q;
  assign rf_clr_addr = rf_clr_addr_q;
  assign pc_load     = pc_load_q;
  assign pc_init     = RESET_PC;
  assign fetch_stall = fetch_stall_q;
  assign halted      = halted_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: directed boot/halt scenarios plus random traffic,
// all checked every cycle against an edge-counting behavioural model.
module tb_cpu_boot_ctrl;

  localparam int HOLD = 16;
  localparam int NREG = 32;
  localparam int S_HOLD  = 0;
  localparam int S_CLR   = 1;
  localparam int S_BOOT  = 2;
  localparam int S_RUN   = 3;
  localparam int S_DRAIN = 4;
  localparam int S_HALT  = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt_req;
  logic        resume_req;
  logic        pipe_empty;
  logic        core_rst_n;
  logic        rf_clr_we;
  logic [4:0]  rf_clr_addr;
  logic        pc_load;
  logic [31:0] pc_init;
  logic        fetch_stall;
  logic        halted;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edges seen with reset_n=1 since last reset, plus post-boot mode.
  int m_k     = 0;
  int m_state = S_HOLD;
  bit m_pend  = 1'b0;

  cpu_boot_ctrl #(
    .HOLD_CYCLES (HOLD),
    .NUM_REGS    (NREG),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .halt_req    (halt_req),
    .resume_req  (resume_req),
    .pipe_empty  (pipe_empty),
    .core_rst_n  (core_rst_n),
    .rf_clr_we   (rf_clr_we),
    .rf_clr_addr (rf_clr_addr),
    .pc_load     (pc_load),
    .pc_init     (pc_init),
    .fetch_stall (fetch_stall),
    .halted      (halted),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_k = 0; m_pend = 1'b0; m_state = S_HOLD;
    end else begin
      case (m_state)
        S_HOLD, S_CLR: begin
          if (halt_req) m_pend = 1'b1;
          m_k++;
          if (m_k < HOLD)             m_state = S_HOLD;
          else if (m_k < HOLD + NREG) m_state = S_CLR;
          else                        m_state = S_BOOT;
        end
        S_BOOT: begin
          if (m_pend || halt_req) begin m_state = S_DRAIN; m_pend = 1'b0; end
          else m_state = S_RUN;
        end
        S_RUN:   if (halt_req) m_state = S_DRAIN;
        S_DRAIN: if (resume_req) m_state = S_RUN; else if (pipe_empty) m_state = S_HALT;
        S_HALT:  if (resume_req) m_state = S_RUN;
        default: m_state = S_HOLD;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("state_o", state_o, m_state);
    check_eq("core_rst_n", core_rst_n, m_state >= S_BOOT);
    check_eq("rf_clr_we", rf_clr_we, m_state == S_CLR);
    if (m_state == S_CLR) check_eq("rf_clr_addr", rf_clr_addr, m_k - HOLD);
    else if (m_k == 0)    check_eq("rf_clr_addr_rst", rf_clr_addr, 0);
    check_eq("pc_load", pc_load, m_state == S_BOOT);
    check_eq("pc_init", pc_init, 32'h0000_0000);
    check_eq("fetch_stall", fetch_stall, m_state != S_RUN);
    check_eq("halted", halted, m_state == S_HALT);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic boot_seq();
    int rise_at;
    int run_at;
    int n_we;
    int n_pl;
    rise_at = -1; run_at = -1; n_we = 0; n_pl = 0;
    reset_n = 1'b1;
    for (int e = 1; e <= 52; e++) begin
      step();
      if (core_rst_n && rise_at < 0) rise_at = e;
      if (!fetch_stall && run_at < 0) run_at = e;
      if (rf_clr_we) begin
        check_eq("clr_addr_order", rf_clr_addr, n_we);
        n_we++;
      end
      if (pc_load) begin
        check_eq("pc_init_at_load", pc_init, 32'h0000_0000);
        n_pl++;
      end
    end
    check_eq("core_rst_n_rise_edge", rise_at, 48);
    check_eq("run_entry_edge", run_at, 49);
    check_eq("clr_we_cycles", n_we, 32);
    check_eq("pc_load_cycles", n_pl, 1);
  endtask

  task automatic wait_addr(input int addr);
    for (int i = 0; i < 60 && !(rf_clr_we && rf_clr_addr == 5'(addr)); i++) step();
    check_eq("clr_addr_reached", rf_clr_addr, addr);
  endtask

  initial begin
    bit saw_run;
    reset_n = 1'b0; halt_req = 1'b0; resume_req = 1'b0; pipe_empty = 1'b0;
    step();
    step();
    check_eq("reset_state", state_o, S_HOLD);
    check_eq("reset_fetch_stall", fetch_stall, 1);

    // Normal boot from release.
    boot_seq();

    // Halt in RUN, drain for 5 cycles, then halt and resume.
    halt_req = 1'b1; step(); halt_req = 1'b0;
    check_eq("drain_entered", state_o, S_DRAIN);
    for (int i = 0; i < 5; i++) step();
    check_eq("still_draining", state_o, S_DRAIN);
    pipe_empty = 1'b1; step();
    check_eq("halted_after_empty", halted, 1);
    resume_req = 1'b1; step(); resume_req = 1'b0;
    check_eq("resume_fetch", fetch_stall, 0);

    // Halt request during the register clear: BOOT goes straight to DRAIN.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    wait_addr(10);
    halt_req = 1'b1; step(); halt_req = 1'b0;
    saw_run = 1'b0;
    for (int i = 0; i < 40 && state_o != 3'd2; i++) begin
      step();
      if (state_o == 3'd3) saw_run = 1'b1;
    end
    check_eq("boot_reached", state_o, S_BOOT);
    step();
    check_eq("pending_halt_drain", state_o, S_DRAIN);
    check_eq("no_run_before_drain", saw_run, 0);
    step();
    check_eq("pending_halt_halted", state_o, S_HALT);

    // Simultaneous events.
    halt_req = 1'b1; resume_req = 1'b1; step(); halt_req = 1'b0; resume_req = 1'b0;
    check_eq("halted_both_gives_run", state_o, S_RUN);
    pipe_empty = 1'b0;
    halt_req = 1'b1; resume_req = 1'b1; step(); halt_req = 1'b0; resume_req = 1'b0;
    check_eq("run_both_gives_drain", state_o, S_DRAIN);
    pipe_empty = 1'b1; resume_req = 1'b1; step(); resume_req = 1'b0;
    check_eq("drain_resume_empty_run", state_o, S_RUN);

    // Reset pulse mid-clear abandons it; full boot follows.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    wait_addr(20);
    reset_n = 1'b0; step();
    check_eq("midclear_rst_we", rf_clr_we, 0);
    check_eq("midclear_rst_state", state_o, S_HOLD);
    boot_seq();

    // Random traffic including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      halt_req   = (m_state != S_BOOT) && ($urandom_range(0, 7) == 0);
      resume_req = ($urandom_range(0, 7) == 0);
      pipe_empty = ($urandom_range(0, 3) != 0);
      reset_n    = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
